// File: rtl/mdu_seq_ctrl.sv
// RV32M multiply/divide sequencer: iterative shift-add multiply and restoring divide.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply, divides unchanged.
module mdu_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            I_valid,
  output logic            O_ready,
  input  logic [2:0]      I_op,
  input  logic [XLEN-1:0] I_src1,
  input  logic [XLEN-1:0] I_src2,
  input  logic [4:0]      I_rd_waddr,
  input  logic            I_flush,
  output logic            O_valid,
  input  logic            I_ready,
  output logic [XLEN-1:0] O_result,
  output logic [4:0]      O_rd_waddr,
  output logic            O_busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;

  function automatic logic [XLEN-1:0] negx(input logic n, input logic [XLEN-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] negp(input logic n, input logic [2*XLEN-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [XLEN-1:0] mul_sel(input logic [2:0] op, input logic [2*XLEN-1:0] p);
    return (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Operand decode at accept: MULH/MULHSU/DIV/REM treat src1 as signed, MULH/DIV/REM src2
  logic            sgn1, sgn2, neg_i, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign sgn1     = (I_op == 3'b001 || I_op == 3'b010 || I_op == 3'b100 || I_op == 3'b110)
                    && I_src1[XLEN-1];
  assign sgn2     = (I_op == 3'b001 || I_op == 3'b100 || I_op == 3'b110) && I_src2[XLEN-1];
  assign mag1     = negx(sgn1, I_src1);
  assign mag2     = negx(sgn2, I_src2);
  assign neg_i    = (I_op == 3'b110) ? sgn1 : (sgn1 ^ sgn2);
  assign div_zero = I_op[2] && (I_src2 == '0);
  assign div_ovf  = I_op[2] && !I_op[0] && (I_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (I_src2 == '1);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

  // One iteration: multiply adds multiplicand on acc LSB then shifts right;
  // divide shifts the next dividend bit into the partial remainder and trial-subtracts.
  logic [XLEN:0]     mul_sum, rem_sh, trial, rem_nxt;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN-1:0]   q_nxt;
  logic              div_ok;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh  = {acc_q[XLEN-1:0], b_q[XLEN-1]};
  assign trial   = rem_sh - {1'b0, a_q};
  assign div_ok  = !trial[XLEN];
  assign rem_nxt = div_ok ? trial : rem_sh;
  assign q_nxt   = {b_q[XLEN-2:0], div_ok};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    if (I_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (I_valid) begin
          op_d  = I_op;
          rd_d  = I_rd_waddr;
          neg_d = neg_i;
          cnt_d = '0;
          if (div_zero) begin
            res_d   = I_op[1] ? I_src1 : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = I_op[1] ? '0 : I_src1;
            state_d = DONE;
`ifdef MDU_FAST_MUL_EN
          end else if (!I_op[2]) begin
            res_d   = mul_sel(I_op, negp(neg_i, fast_prod));
            state_d = DONE;
`endif
          end else if (I_op[2]) begin
            a_d     = mag2;
            b_d     = mag1;
            acc_d   = '0;
            state_d = CALC;
          end else begin
            a_d     = mag1;
            acc_d   = {{XLEN{1'b0}}, mag2};
            state_d = CALC;
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            acc_d = {{(XLEN-1){1'b0}}, rem_nxt};
            b_d   = q_nxt;
          end else begin
            acc_d = mul_nxt;
          end
          if (cnt_q == '1) begin
            state_d = DONE;
            if (op_q[2])
              res_d = op_q[1] ? negx(neg_q, rem_nxt[XLEN-1:0]) : negx(neg_q, q_nxt);
            else
              res_d = mul_sel(op_q, negp(neg_q, mul_nxt));
          end
        end
        DONE: if (I_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    neg_q <= neg_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign O_ready    = (state_q == IDLE) && !rst;
  assign O_busy     = !O_ready;
  assign O_valid    = (state_q == DONE);
  assign O_result   = res_q;
  assign O_rd_waddr = rd_q;

endmodule
